lse_simd_2x12b_packer: RTL and testbench
========================================

# lse_simd_2x12b_packer

Upstream operand stage for the dual-channel 12-bit SIMD LSE unit. Accepts a scalar stream of 12-bit log-domain operand pairs (x, y) over a valid/ready handshake. Packs two consecutive pairs into one 24-bit SIMD word: first pair in lane 0 `[11:0]`, second pair in lane 1 `[23:12]`. Buffers packed words in a small first-word-fall-through FIFO, from which the SIMD issue logic pops.

## Interface
- CHANNEL_WIDTH, 12, lane width in bits
- DATA_WIDTH, 24, packed word width (2 × CHANNEL_WIDTH)
- FIFO_DEPTH, 4, packed-word FIFO entries; power of two, ≥ 2
- PAD_VALUE, 12'h800, filler for an unused lane 1 (most negative code, log-domain "−∞")

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  1  scalar pair offered
- in_ready  output  1  scalar pair can be accepted
- in_x  input  CHANNEL_WIDTH  operand x
- in_y  input  CHANNEL_WIDTH  operand y
- in_last  input  1  final pair of a vector; forces the current word out
- out_valid  output  1  FIFO head holds a packed word
- out_ready  input  1  consumer pops the head this cycle
- out_x  output  DATA_WIDTH  packed x; `[23:12]` = lane 1, `[11:0]` = lane 0
- out_y  output  DATA_WIDTH  packed y, same layout
- out_lane_mask  output  2  bit i = lane i carries real data
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries

## Operation
- In-handshake: a transfer occurs when `in_valid && in_ready`. Out-handshake: a pop occurs when `out_valid && out_ready`.
- Pack FSM states:
  - LANE0_FREE (reset state): no pending lane.
  - LANE0_HELD: hold register contains the lane-0 x/y.
- Transitions on an accepted transfer:
  - LANE0_FREE, in_last=0: store x/y in the hold register; go to LANE0_HELD. Nothing is pushed.
  - LANE0_FREE, in_last=1: push {PAD_VALUE, in} for x and y, mask=2'b01; stay in LANE0_FREE.
  - LANE0_HELD (any in_last): push {in, hold}, mask=2'b11; go to LANE0_FREE. Here in_last needs no special handling.
- `in_ready = (fifo_count != FIFO_DEPTH)`. There is no combinational path from out_ready, so a full FIFO stalls input even in LANE0_FREE.
- FIFO behaviour:
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Pop when empty is impossible, since out_valid=0.
- Outputs:
  - `out_valid = (fifo_count != 0)`.
  - out_x, out_y and out_lane_mask show the head entry when out_valid=1, and are forced to 0 when empty.
  - Data are held stable while out_valid=1 and out_ready=0.
- Lanes are independent raw bit fields. No arithmetic, saturation or reordering is applied.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM → LANE0_FREE; hold register cleared; pointers and count = 0.
  - out_valid=0, out_x=0, out_y=0, out_lane_mask=0, fifo_count=0, in_ready=1.
  - Reset mid-vector discards the held lane and all FIFO contents. No partial word is emitted after reset release.
- Latency: the transfer that completes a word at edge N gives out_valid=1 after edge N, provided the FIFO was empty.
- Throughput: one scalar pair per cycle, i.e. one packed word every 2 cycles at steady state (one per cycle under in_last=1).
- fifo_count is registered and updates at the same edge as the push/pop.
- Full condition: with fifo_count = FIFO_DEPTH, in_ready=0. A pop at edge N makes in_ready=1 after edge N.

## Test plan
- Basic pair: reset, then send (x=12'h123, y=12'h456) and (12'h789, 12'hABC) with out_ready=1 → one word: out_x=24'h789123, out_y=24'hABC456, mask=2'b11, out_valid high for 1 cycle.
- Odd-length flush: send 3 pairs, the third with in_last=1 and x=12'h00F, y=12'h0F0 → second word: out_x=24'h80000F, out_y=24'h8000F0, mask=2'b01.
- Backpressure/full: out_ready=0, stream 10 pairs with FIFO_DEPTH=4 → fifo_count reaches 4 and in_ready drops after the 8th pair. Releasing out_ready then drains 4 words in order. Remaining pairs are accepted and no data is lost or duplicated.
- Simultaneous push/pop: at fifo_count=2, complete a word on the same edge as a pop → fifo_count stays 2. The head advances to the next word, and pointer wrap is exercised over 3 full FIFO laps.
- Async reset mid-vector: in LANE0_HELD with 2 words queued, pulse rst_n low between clock edges → outputs go to 0 immediately. After release, the next 2 pairs form a fresh word with no trace of the held lane.

Source files
------------

// File: rtl/lse_simd_2x12b_packer.sv
// rtl/lse_simd_2x12b_packer.sv - packs two scalar 12-bit x/y pairs into one SIMD word and queues it in a FWFT FIFO
module lse_simd_2x12b_packer #(
  parameter int CHANNEL_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter logic [CHANNEL_WIDTH-1:0] PAD_VALUE = 12'h800
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNEL_WIDTH-1:0]      in_x,
  input  logic [CHANNEL_WIDTH-1:0]      in_y,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_x,
  output logic [DATA_WIDTH-1:0]         out_y,
  output logic [1:0]                    out_lane_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    LANE0_FREE,
    LANE0_HELD
  } state_t;

  state_t                   state;
  logic [CHANNEL_WIDTH-1:0] hold_x;
  logic [CHANNEL_WIDTH-1:0] hold_y;

  logic                     accept;
  logic                     pop;
  logic                     push;
  logic [DATA_WIDTH-1:0]    push_x;
  logic [DATA_WIDTH-1:0]    push_y;
  logic [1:0]               push_mask;

  logic [DATA_WIDTH-1:0]    mem_x [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    mem_y [FIFO_DEPTH];
  logic [1:0]               mem_mask [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;

  // Input readiness depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count != DEPTH_C);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign fifo_count = count;

  // Pack FSM: park lane 0 in the hold register until lane 1 or in_last arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LANE0_FREE;
      hold_x <= '0;
      hold_y <= '0;
    end else if (accept) begin
      case (state)
        LANE0_FREE: begin
          if (!in_last) begin
            hold_x <= in_x;
            hold_y <= in_y;
            state  <= LANE0_HELD;
          end
        end
        default: state <= LANE0_FREE;
      endcase
    end
  end

  // Word assembly: a held lane 0 is always completed; a lone last pair pads lane 1.
  always_comb begin
    push      = 1'b0;
    push_x    = '0;
    push_y    = '0;
    push_mask = 2'b00;
    if (accept) begin
      if (state == LANE0_HELD) begin
        push      = 1'b1;
        push_x    = {in_x, hold_x};
        push_y    = {in_y, hold_y};
        push_mask = 2'b11;
      end else if (in_last) begin
        push      = 1'b1;
        push_x    = {PAD_VALUE, in_x};
        push_y    = {PAD_VALUE, in_y};
        push_mask = 2'b01;
      end
    end
  end

  // FIFO storage; stale entries are never visible because the outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr]    <= push_x;
      mem_y[wr_ptr]    <= push_y;
      mem_mask[wr_ptr] <= push_mask;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign out_x         = out_valid ? mem_x[rd_ptr]    : '0;
  assign out_y         = out_valid ? mem_y[rd_ptr]    : '0;
  assign out_lane_mask = out_valid ? mem_mask[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_lse_simd_2x12b_packer.sv
// tb/tb_lse_simd_2x12b_packer.sv - randomized self-checking bench for lse_simd_2x12b_packer
module tb_lse_simd_2x12b_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_x;
  logic [11:0] in_y;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_x;
  logic [23:0] out_y;
  logic [1:0]  out_lane_mask;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic        r;
    logic [23:0] x;
    logic [23:0] y;
    logic [1:0]  m;
    logic [2:0]  c;
  } snap_t;

  // Reference model: queue of packed words plus an optional pending lane-0 pair.
  logic [23:0] mx[$];
  logic [23:0] my[$];
  logic [1:0]  mm[$];
  logic        have_pend;
  logic [11:0] pend_x;
  logic [11:0] pend_y;

  lse_simd_2x12b_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_lane_mask(out_lane_mask),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    mx.delete(); my.delete(); mm.delete();
    have_pend = 1'b0; pend_x = '0; pend_y = '0;
  endtask

  task automatic model_accept(input logic [11:0] x, input logic [11:0] y, input logic last);
    if (have_pend) begin
      mx.push_back({x, pend_x}); my.push_back({y, pend_y}); mm.push_back(2'b11);
      have_pend = 1'b0;
    end else if (last) begin
      mx.push_back({12'h800, x}); my.push_back({12'h800, y}); mm.push_back(2'b01);
    end else begin
      pend_x = x; pend_y = y; have_pend = 1'b1;
    end
  endtask

  // One clock of stimulus; returns what the DUT shows and what the model predicts before the edge.
  task automatic drive(input logic v, input logic [11:0] x, input logic [11:0] y,
                       input logic last, input logic rdy,
                       output snap_t obs, output snap_t exp, output logic acc);
    logic pop;
    in_valid = v; in_x = x; in_y = y; in_last = last; out_ready = rdy;
    #1;
    obs = {out_valid, in_ready, out_x, out_y, out_lane_mask, fifo_count};
    exp.v = (mx.size() != 0);
    exp.r = (mx.size() != 4);
    exp.x = exp.v ? mx[0] : 24'h0;
    exp.y = exp.v ? my[0] : 24'h0;
    exp.m = exp.v ? mm[0] : 2'b00;
    exp.c = 3'(mx.size());
    acc = v && exp.r;
    pop = exp.v && rdy;
    @(posedge clk); #1;
    if (pop) begin mx.delete(0); my.delete(0); mm.delete(0); end
    if (acc) model_accept(x, y, last);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, out_x, out_y, out_lane_mask, fifo_count} !== {1'b0, 1'b1, 48'h0, 2'b00, 3'd0}) begin
      errors++;
      $display("FAIL reset_state v=%b r=%b x=%h y=%h m=%b c=%0d required v=0 r=1 x=0 y=0 m=0 c=0",
               out_valid, in_ready, out_x, out_y, out_lane_mask, fifo_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_pair();
    snap_t obs, exp;
    logic acc;
    logic [11:0] xs[4];
    logic [11:0] ys[4];
    xs = '{12'h123, 12'h789, 12'h000, 12'h000};
    ys = '{12'h456, 12'hABC, 12'h000, 12'h000};
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, xs[i], ys[i], 1'b0, 1'b1, obs, exp, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic_pair cyc%0d got v=%b r=%b x=%h y=%h m=%b c=%0d required v=%b r=%b x=%h y=%h m=%b c=%0d",
                 i, obs.v, obs.r, obs.x, obs.y, obs.m, obs.c, exp.v, exp.r, exp.x, exp.y, exp.m, exp.c);
      end
      if (i == 2) begin
        checks++;
        if ({obs.v, obs.x, obs.y, obs.m} !== {1'b1, 24'h789123, 24'hABC456, 2'b11}) begin
          errors++;
          $display("FAIL basic_word got v=%b x=%h y=%h m=%b required v=1 x=789123 y=abc456 m=11",
                   obs.v, obs.x, obs.y, obs.m);
        end
      end
    end
  endtask

  task automatic test_odd_flush();
    snap_t obs, exp;
    logic acc;
    for (int i = 0; i < 6; i++) begin
      if (i < 2)       drive(1'b1, 12'($urandom), 12'($urandom), 1'b0, 1'b1, obs, exp, acc);
      else if (i == 2) drive(1'b1, 12'h00F, 12'h0F0, 1'b1, 1'b1, obs, exp, acc);
      else             drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, obs, exp, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL odd_flush cyc%0d got v=%b r=%b x=%h y=%h m=%b c=%0d required v=%b r=%b x=%h y=%h m=%b c=%0d",
                 i, obs.v, obs.r, obs.x, obs.y, obs.m, obs.c, exp.v, exp.r, exp.x, exp.y, exp.m, exp.c);
      end
      if (i == 3) begin
        checks++;
        if ({obs.v, obs.x, obs.y, obs.m} !== {1'b1, 24'h80000F, 24'h8000F0, 2'b01}) begin
          errors++;
          $display("FAIL odd_pad_word got v=%b x=%h y=%h m=%b required v=1 x=80000f y=8000f0 m=01",
                   obs.v, obs.x, obs.y, obs.m);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    snap_t obs, exp;
    logic acc;
    logic [11:0] px[10];
    logic [11:0] py[10];
    int sent = 0;
    int pops = 0;
    int cyc = 0;
    for (int i = 0; i < 10; i++) begin px[i] = 12'($urandom); py[i] = 12'($urandom); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, px[sent], py[sent], 1'b0, 1'b0, obs, exp, acc);
      if (acc) sent++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL backpressure_fill cyc%0d got v=%b r=%b x=%h m=%b c=%0d required v=%b r=%b x=%h m=%b c=%0d",
                 i, obs.v, obs.r, obs.x, obs.m, obs.c, exp.v, exp.r, exp.x, exp.m, exp.c);
      end
    end
    checks++;
    if ({obs.r, obs.c} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL backpressure_full got in_ready=%b count=%0d required in_ready=0 count=4", obs.r, obs.c);
    end
    while ((sent < 10 || mx.size() != 0) && cyc < 40) begin
      drive(sent < 10, (sent < 10) ? px[sent] : 12'h0, (sent < 10) ? py[sent] : 12'h0,
            1'b0, 1'b1, obs, exp, acc);
      if (acc) sent++;
      if (obs.v === 1'b1) pops++;
      cyc++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL backpressure_drain cyc%0d got v=%b r=%b x=%h y=%h m=%b c=%0d required v=%b r=%b x=%h y=%h m=%b c=%0d",
                 cyc, obs.v, obs.r, obs.x, obs.y, obs.m, obs.c, exp.v, exp.r, exp.x, exp.y, exp.m, exp.c);
      end
    end
    checks++;
    if (cyc >= 40 || pops != 5) begin
      errors++;
      $display("FAIL backpressure_words got pops=%0d cycles=%0d required pops=5 within 40 cycles", pops, cyc);
    end
  endtask

  task automatic test_simul_push_pop();
    snap_t obs, exp;
    logic acc;
    int cyc = 0;
    for (int i = 0; i < 7; i++) begin
      drive(i < 6, 12'($urandom), 12'($urandom), 1'b0, i == 5, obs, exp, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simul_setup cyc%0d got v=%b r=%b x=%h m=%b c=%0d required v=%b r=%b x=%h m=%b c=%0d",
                 i, obs.v, obs.r, obs.x, obs.m, obs.c, exp.v, exp.r, exp.x, exp.m, exp.c);
      end
    end
    checks++;
    if (obs.c !== 3'd2) begin
      errors++;
      $display("FAIL simul_count got count=%0d required 2", obs.c);
    end
    for (int i = 0; i < 90; i++) begin
      drive($urandom_range(0, 9) < 8, 12'($urandom), 12'($urandom),
            $urandom_range(0, 9) < 2 || i == 89, $urandom_range(0, 9) < 6, obs, exp, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simul_random cyc%0d got v=%b r=%b x=%h y=%h m=%b c=%0d required v=%b r=%b x=%h y=%h m=%b c=%0d",
                 i, obs.v, obs.r, obs.x, obs.y, obs.m, obs.c, exp.v, exp.r, exp.x, exp.y, exp.m, exp.c);
      end
    end
    while ((mx.size() != 0 || have_pend) && cyc < 20) begin
      drive(have_pend, 12'($urandom), 12'($urandom), 1'b1, 1'b1, obs, exp, acc);
      cyc++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simul_drain cyc%0d got v=%b x=%h m=%b c=%0d required v=%b x=%h m=%b c=%0d",
                 cyc, obs.v, obs.x, obs.m, obs.c, exp.v, exp.x, exp.m, exp.c);
      end
    end
    checks++;
    if (cyc >= 20) begin
      errors++;
      $display("FAIL simul_drain_timeout got cycles=%0d required <20", cyc);
    end
  endtask

  task automatic test_async_reset();
    snap_t obs, exp;
    logic acc;
    logic [11:0] x1, y1, x2, y2;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 12'($urandom), 12'($urandom), 1'b0, 1'b0, obs, exp, acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_x, out_y, out_lane_mask, fifo_count} !== {1'b0, 1'b1, 48'h0, 2'b00, 3'd0}) begin
      errors++;
      $display("FAIL async_reset got v=%b r=%b x=%h y=%h m=%b c=%0d required v=0 r=1 x=0 y=0 m=0 c=0",
               out_valid, in_ready, out_x, out_y, out_lane_mask, fifo_count);
    end
    model_clear();
    #2;
    rst_n = 1'b1;
    x1 = 12'($urandom); y1 = 12'($urandom); x2 = 12'($urandom); y2 = 12'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      drive(1'b1, x1, y1, 1'b0, 1'b0, obs, exp, acc);
      else if (i == 1) drive(1'b1, x2, y2, 1'b0, 1'b0, obs, exp, acc);
      else             drive(1'b0, 12'h0, 12'h0, 1'b0, 1'b1, obs, exp, acc);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL async_after cyc%0d got v=%b r=%b x=%h y=%h m=%b c=%0d required v=%b r=%b x=%h y=%h m=%b c=%0d",
                 i, obs.v, obs.r, obs.x, obs.y, obs.m, obs.c, exp.v, exp.r, exp.x, exp.y, exp.m, exp.c);
      end
      if (i == 2) begin
        checks++;
        if ({obs.v, obs.x, obs.y, obs.m, obs.c} !== {1'b1, x2, x1, y2, y1, 2'b11, 3'd1}) begin
          errors++;
          $display("FAIL async_fresh_word got v=%b x=%h y=%h m=%b c=%0d required v=1 x=%h%h y=%h%h m=11 c=1",
                   obs.v, obs.x, obs.y, obs.m, obs.c, x2, x1, y2, y1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_odd_flush();
    test_backpressure();
    test_simul_push_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
